// File: rtl/idc_divider_pkg.sv
// Shared DPLL definitions: credit-register width helper and period-length codes
// for the increment-decrement counter.
package idc_divider_pkg;

  localparam logic [1:0] LEN_ADV = 2'd1;
  localparam logic [1:0] LEN_NOM = 2'd2;
  localparam logic [1:0] LEN_RET = 2'd3;

  // One sign bit on top of the bits needed to hold +pend_max.
  function automatic int pend_width(input int pend_max);
    return $clog2(pend_max + 1) + 1;
  endfunction

endpackage

// File: rtl/idc_divider_fout_divider.sv
// Mod-N counter clocked by the ID-counter enable; produces the recovered
// 50 % duty square wave and a one-cycle marker on each wrap to zero.
module fout_divider #(
  parameter int N = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  output logic f_out,
  output logic phase_edge
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [CW-1:0] HALF = CW'(N / 2);

  logic [CW-1:0] div_cnt;
  logic [CW-1:0] div_nxt;

  always_comb begin
    div_nxt = (div_cnt == LAST) ? '0 : div_cnt + CW'(1);
  end

  // Reset to N-1 so the very first tick wraps to 0 and raises phase_edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt    <= LAST;
      f_out      <= 1'b0;
      phase_edge <= 1'b0;
    end else if (tick) begin
      div_cnt    <= div_nxt;
      f_out      <= (div_nxt < HALF);
      phase_edge <= (div_nxt == '0);
    end else begin
      phase_edge <= 1'b0;
    end
  end

endmodule

// File: rtl/idc_divider.sv
// DPLL increment-decrement counter with saturating correction credit, followed
// by a divide-by-N stage producing the recovered clock and phase marker.
module idc_divider
  import idc_divider_pkg::*;
#(
  parameter int N        = 8,
  parameter int PEND_MAX = 3,
  localparam int PW      = pend_width(PEND_MAX)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 carry,
  input  logic                 borrow,
  input  logic                 clrOvf,
  output logic                 idOut,
  output logic                 fOut,
  output logic                 phaseEdge,
  output logic signed [PW-1:0] pend,
  output logic                 ovf
);

  // Two guard bits cover pend + delta + consume before clamping.
  localparam int SW = PW + 2;
  localparam logic signed [SW-1:0] PMAX = SW'(PEND_MAX);
  localparam logic signed [SW-1:0] PMIN = -PMAX;

  logic [1:0]           ph;
  logic [1:0]           len;
  logic                 ph_zero;
  logic signed [SW-1:0] pend_ext;
  logic signed [SW-1:0] delta;
  logic signed [SW-1:0] consume;
  logic signed [SW-1:0] sum;
  logic                 clip;

  function automatic logic signed [PW-1:0] sat(input logic signed [SW-1:0] v);
    if (v > PMAX)      return PMAX[PW-1:0];
    else if (v < PMIN) return PMIN[PW-1:0];
    else               return v[PW-1:0];
  endfunction

  always_comb begin
    ph_zero  = (ph == 2'd0);
    pend_ext = {{2{pend[PW-1]}}, pend};
    len      = LEN_NOM;
    if (pend > 0)      len = LEN_ADV;
    else if (pend < 0) len = LEN_RET;

    delta = '0;
    if (enable && carry && !borrow)      delta = {{(SW-1){1'b0}}, 1'b1};
    else if (enable && borrow && !carry) delta = '1;

    // Credit is spent only when a new period is being chosen.
    consume = '0;
    if (ph_zero && pend > 0)      consume = '1;
    else if (ph_zero && pend < 0) consume = {{(SW-1){1'b0}}, 1'b1};

    sum  = pend_ext + delta + consume;
    clip = (sum > PMAX) || (sum < PMIN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ph    <= 2'd1;
      idOut <= 1'b0;
      pend  <= '0;
      ovf   <= 1'b0;
    end else begin
      if (ph_zero) begin
        idOut <= 1'b1;
        ph    <= len - 2'd1;
      end else begin
        idOut <= 1'b0;
        ph    <= ph - 2'd1;
      end

      if (!enable) pend <= '0;
      else         pend <= sat(sum);

      if (enable && clip) ovf <= 1'b1;
      else if (clrOvf)    ovf <= 1'b0;
    end
  end

  fout_divider #(
    .N(N)
  ) u_fout_divider (
    .clk       (clk),
    .reset     (reset),
    .tick      (ph_zero),
    .f_out     (fOut),
    .phase_edge(phaseEdge)
  );

endmodule
